// File: rtl/hex_report_pkg.sv
// Shared definitions for the hex report transmitter: sequencer states,
// ASCII constants and the last character index for each build flavour.
// The optional CR/LF terminator build is selected with HEX_REPORT_CRLF_EN.
package hex_report_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STROBE  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    NEXT    = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  // Index of the final character in a report: two hex digits, optionally
  // followed by CR and LF.
  localparam logic [1:0] LAST_IDX_HEX  = 2'd1;
  localparam logic [1:0] LAST_IDX_CRLF = 2'd3;

endpackage

// File: rtl/hex_report_tx_nibble_to_ascii.sv
// Converts one 4-bit nibble into its ASCII hex digit. HEX_UPPER selects
// upper-case (1) or lower-case (0) letters for the values 10..15.
module nibble_to_ascii
  import hex_report_pkg::*;
#(
  parameter int HEX_UPPER = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits are offset from '0'; letters are offset from 'A' or 'a'.
  always_comb begin
    ascii = ASCII_ZERO + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = ((HEX_UPPER != 0) ? ASCII_UPPER_A : ASCII_LOWER_A)
              + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_report_tx.sv
// Reports a byte as two ASCII hex characters to a UART transmitter using a
// data-ready strobe and the transmitter's busy flag as handshake.
// Define HEX_REPORT_CRLF_EN to append CR and LF after the two digits.
module hex_report_tx
  import hex_report_pkg::*;
#(
  parameter int HEX_UPPER = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_send,
  input  logic [7:0] i_value,
  input  logic       i_tx_busy,
  output logic       o_tx_dr,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun
);

`ifdef HEX_REPORT_CRLF_EN
  localparam logic [1:0] LAST_IDX = LAST_IDX_CRLF;
`else
  localparam logic [1:0] LAST_IDX = LAST_IDX_HEX;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [7:0] value_q;
  logic [1:0] idx;
  logic [3:0] nibble;
  logic [7:0] nibble_ascii;
  logic [7:0] char_sel;

  // Index 0 reports the upper nibble, index 1 the lower nibble.
  assign nibble = (idx == 2'd0) ? value_q[7:4] : value_q[3:0];

  nibble_to_ascii #(
    .HEX_UPPER(HEX_UPPER)
  ) u_nibble_to_ascii (
    .nibble(nibble),
    .ascii (nibble_ascii)
  );

  // Pick the character for the current index, terminators included.
  always_comb begin
    char_sel = nibble_ascii;
`ifdef HEX_REPORT_CRLF_EN
    if (idx == 2'd2) begin
      char_sel = ASCII_CR;
    end else if (idx == 2'd3) begin
      char_sel = ASCII_LF;
    end
`endif
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: load, strobe, then follow busy high and back low.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_send)     state_nxt = LOAD;
      LOAD:                    state_nxt = STROBE;
      STROBE:  if (!i_tx_busy) state_nxt = WAIT_HI;
      WAIT_HI: if (i_tx_busy)  state_nxt = WAIT_LO;
      WAIT_LO: if (!i_tx_busy) state_nxt = NEXT;
      NEXT:    state_nxt = (idx == LAST_IDX) ? IDLE : LOAD;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Registered datapath and output pulses; o_done is raised on entry to
  // NEXT so its cycle still counts as busy for overrun purposes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      value_q   <= 8'h00;
      idx       <= 2'd0;
      o_tx_data <= 8'h00;
      o_tx_dr   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_tx_dr   <= (state == STROBE) && !i_tx_busy;
      o_done    <= (state == WAIT_LO) && !i_tx_busy && (idx == LAST_IDX);
      o_overrun <= i_send && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_send) begin
            value_q <= i_value;
            idx     <= 2'd0;
            o_busy  <= 1'b1;
          end
        end
        LOAD: begin
          o_tx_data <= char_sel;
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            o_busy <= 1'b0;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_report_tx.sv
// Self-checking bench for hex_report_tx: an upper-case and a lower-case
// instance share all inputs and a simple UART busy model; a per-instance
// behavioural model predicts characters, handshake legality, busy, done
// and overrun. Honours HEX_REPORT_CRLF_EN for the expected character count.
module tb_hex_report_tx;

`ifdef HEX_REPORT_CRLF_EN
  localparam int N_CHARS = 4;
`else
  localparam int N_CHARS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       send = 1'b0;
  logic [7:0] value = 8'h00;
  logic       xmit_busy = 1'b0;
  logic       ext_busy = 1'b0;
  logic       tx_busy;

  logic       dr0, busy0, done0, ovr0, dr1, busy1, done1, ovr1;
  logic [7:0] data0, data1;

  logic [1:0] dr_v, busy_v, done_v, ovr_v;
  logic [7:0] data_v [2];

  assign tx_busy   = xmit_busy | ext_busy;
  assign dr_v      = {dr1, dr0};
  assign busy_v    = {busy1, busy0};
  assign done_v    = {done1, done0};
  assign ovr_v     = {ovr1, ovr0};
  assign data_v[0] = data0;
  assign data_v[1] = data1;

  hex_report_tx #(.HEX_UPPER(1)) u_dut_uc (
    .i_clk(clk), .i_reset(rst_n), .i_send(send), .i_value(value),
    .i_tx_busy(tx_busy), .o_tx_dr(dr0), .o_tx_data(data0),
    .o_busy(busy0), .o_done(done0), .o_overrun(ovr0)
  );

  hex_report_tx #(.HEX_UPPER(0)) u_dut_lc (
    .i_clk(clk), .i_reset(rst_n), .i_send(send), .i_value(value),
    .i_tx_busy(tx_busy), .o_tx_dr(dr1), .o_tx_data(data1),
    .o_busy(busy1), .o_done(done1), .o_overrun(ovr1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected character for a report position, straight from the encoding rules.
  function automatic logic [7:0] exp_char(input logic [7:0] v, input int pos, input bit upper);
    logic [3:0] n;
    if (pos == 2) return 8'h0D;
    if (pos == 3) return 8'h0A;
    n = (pos == 0) ? v[7:4] : v[3:0];
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (upper ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // UART model: busy rises one cycle after a strobe and stays high 10 cycles.
  int hold = 0;
  bit pending = 1'b0;
  always @(posedge clk) begin
    #2;
    if (hold > 0) begin
      hold--;
      if (hold == 0) xmit_busy = 1'b0;
    end
    if (pending) begin
      xmit_busy = 1'b1;
      hold      = 10;
      pending   = 1'b0;
    end
    if (dr0) pending = 1'b1;
  end

  // Behavioural model state, one copy per instance.
  bit         act [2];
  int         nsent [2];
  int         hs [2];
  bit         done_due [2];
  bit         ovr_due [2];
  int         lat_cnt [2];
  bit         lat_clean [2];
  logic [7:0] cur_val [2];
  logic [7:0] last_ch [2];
  int         done_cnt [2];
  int         ovr_cnt [2];
  bit         prev_busy = 1'b0;
  logic [7:0] log0 [$];
  logic [7:0] log1 [$];

  // Compare process: checks every output of both instances mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        checkOutput($sformatf("rst_dr%0d", i), int'(dr_v[i]), 0);
        checkOutput($sformatf("rst_data%0d", i), int'(data_v[i]), 0);
        checkOutput($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
        checkOutput($sformatf("rst_done%0d", i), int'(done_v[i]), 0);
        checkOutput($sformatf("rst_ovr%0d", i), int'(ovr_v[i]), 0);
        act[i] = 0; nsent[i] = 0; hs[i] = 2; done_due[i] = 0;
        ovr_due[i] = 0; last_ch[i] = 8'h00; lat_clean[i] = 0;
      end else begin
        bit exp_d;
        bit legal;
        logic [7:0] e;
        exp_d = done_due[i];
        done_due[i] = 0;
        checkOutput($sformatf("done%0d", i), int'(done_v[i]), int'(exp_d));
        if (done_v[i]) done_cnt[i]++;
        checkOutput($sformatf("overrun%0d", i), int'(ovr_v[i]), int'(ovr_due[i]));
        if (ovr_v[i]) ovr_cnt[i]++;
        ovr_due[i] = 0;
        checkOutput($sformatf("busy%0d", i), int'(busy_v[i]), int'(act[i]));
        if (act[i] && nsent[i] == 0) begin
          lat_cnt[i]++;
          if (prev_busy) lat_clean[i] = 0;
        end
        if (dr_v[i]) begin
          legal = act[i] && (nsent[i] < N_CHARS) && (hs[i] == 2) && !prev_busy;
          checkOutput($sformatf("strobe_legal%0d", i), int'(legal), 1);
          if (act[i] && nsent[i] < N_CHARS) begin
            e = exp_char(cur_val[i], nsent[i], i == 0);
            checkOutput($sformatf("char%0d_%0d", i, nsent[i]), int'(data_v[i]), int'(e));
            if (nsent[i] == 0 && lat_clean[i])
              checkOutput($sformatf("latency%0d", i), lat_cnt[i], 3);
            last_ch[i] = e;
            nsent[i]++;
          end
          hs[i] = 0;
          if (i == 0) log0.push_back(data_v[i]); else log1.push_back(data_v[i]);
        end else if (!act[i] || hs[i] != 2) begin
          checkOutput($sformatf("hold%0d", i), int'(data_v[i]), int'(last_ch[i]));
        end
        if (hs[i] == 0 && tx_busy) begin
          hs[i] = 1;
        end else if (hs[i] == 1 && !tx_busy) begin
          hs[i] = 2;
          if (act[i] && nsent[i] == N_CHARS) done_due[i] = 1;
        end
        if (send) begin
          if (act[i]) begin
            ovr_due[i] = 1;
          end else begin
            act[i] = 1; cur_val[i] = value; nsent[i] = 0; hs[i] = 2;
            lat_cnt[i] = 0; lat_clean[i] = 1;
          end
        end
        if (exp_d) act[i] = 0;
      end
    end
    prev_busy = tx_busy;
  end

  task automatic applyStimulus(input logic [7:0] v);
    @(posedge clk); #1;
    send = 1'b1; value = v;
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input bit spam);
    int b;
    b = budget;
    while (done_cnt[0] < target && b > 0) begin
      if (spam) begin
        send  = ($urandom_range(0, 7) == 0);
        value = 8'($urandom);
      end
      @(posedge clk); #1;
      b--;
    end
    send = 1'b0;
    checkOutput("done_seen", int'(done_cnt[0] >= target), 1);
  endtask

  task automatic waitStrobes(input int n, input int budget);
    int b;
    b = budget;
    while (log0.size() < n && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    checkOutput("strobe_wait", int'(log0.size() >= n), 1);
  endtask

  task automatic checkLog(input string tag, input logic [7:0] exp_uc [4], input logic [7:0] exp_lc [4]);
    checkOutput({tag, "_count_uc"}, log0.size(), N_CHARS);
    checkOutput({tag, "_count_lc"}, log1.size(), N_CHARS);
    for (int k = 0; k < N_CHARS; k++) begin
      if (k < log0.size()) checkOutput($sformatf("%s_uc%0d", tag, k), int'(log0[k]), int'(exp_uc[k]));
      if (k < log1.size()) checkOutput($sformatf("%s_lc%0d", tag, k), int'(log1[k]), int'(exp_lc[k]));
    end
  endtask

  task automatic clearLogs();
    log0.delete();
    log1.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] eu [4];
    logic [7:0] el [4];
    int d0;
    int o0;
    int hits;
    int k;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx_data", int'(data0), 0);
    checkOutput("reset_busy", int'(busy0), 0);
    checkOutput("reset_dr", int'(dr0), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] report 0x4A");
    clearLogs(); d0 = done_cnt[0];
    applyStimulus(8'h4A);
    waitDone(d0 + 1, 200, 1'b0);
    eu = '{8'h34, 8'h41, 8'h0D, 8'h0A}; el = '{8'h34, 8'h61, 8'h0D, 8'h0A};
    checkLog("r4A", eu, el);
    checkOutput("r4A_done_once", done_cnt[0] - d0, 1);

    $display("[TB] report 0xFB");
    clearLogs(); d0 = done_cnt[0];
    applyStimulus(8'hFB);
    waitDone(d0 + 1, 200, 1'b0);
    eu = '{8'h46, 8'h42, 8'h0D, 8'h0A}; el = '{8'h66, 8'h62, 8'h0D, 8'h0A};
    checkLog("rFB", eu, el);

    $display("[TB] report 0x00");
    clearLogs(); d0 = done_cnt[0];
    applyStimulus(8'h00);
    waitDone(d0 + 1, 200, 1'b0);
    eu = '{8'h30, 8'h30, 8'h0D, 8'h0A}; el = eu;
    checkLog("r00", eu, el);

    $display("[TB] overrun during second character");
    clearLogs(); d0 = done_cnt[0]; o0 = ovr_cnt[0];
    applyStimulus(8'h4A);
    waitStrobes(2, 200);
    send = 1'b1; value = 8'h11;
    @(posedge clk); #1;
    send = 1'b0;
    waitDone(d0 + 1, 200, 1'b0);
    eu = '{8'h34, 8'h41, 8'h0D, 8'h0A}; el = '{8'h34, 8'h61, 8'h0D, 8'h0A};
    checkLog("ovr", eu, el);
    checkOutput("ovr_pulses", ovr_cnt[0] - o0, 1);
    hits = 0;
    foreach (log0[j]) if (log0[j] == 8'h31) hits++;
    checkOutput("ovr_no_0x31", hits, 0);

    $display("[TB] send on done cycle, then on the next cycle");
    clearLogs(); d0 = done_cnt[0]; o0 = ovr_cnt[0];
    applyStimulus(8'h12);
    k = 0;
    while (!done0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("done_edge_seen", int'(done0), 1);
    send = 1'b1; value = 8'h99;
    @(posedge clk); #1;
    value = 8'h5C;
    @(posedge clk); #1;
    send = 1'b0;
    waitDone(d0 + 2, 300, 1'b0);
    checkOutput("done_edge_ovr", ovr_cnt[0] - o0, 1);
    checkOutput("done_edge_chars", log0.size(), 2 * N_CHARS);
    if (log0.size() == 2 * N_CHARS) begin
      checkOutput("done_edge_c0", int'(log0[N_CHARS]), 8'h35);
      checkOutput("done_edge_c1", int'(log0[N_CHARS + 1]), 8'h43);
    end

    $display("[TB] reset during WAIT_LO of the first character");
    clearLogs(); d0 = done_cnt[0];
    applyStimulus(8'h4A);
    waitStrobes(1, 200);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_dr", int'(dr0), 0);
    checkOutput("midrst_data", int'(data0), 0);
    checkOutput("midrst_busy", int'(busy0), 0);
    checkOutput("midrst_done", int'(done0), 0);
    checkOutput("midrst_ovr", int'(ovr0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", done_cnt[0] - d0, 0);
    clearLogs(); d0 = done_cnt[0];
    applyStimulus(8'h7E);
    waitDone(d0 + 1, 200, 1'b0);
    eu = '{8'h37, 8'h45, 8'h0D, 8'h0A}; el = '{8'h37, 8'h65, 8'h0D, 8'h0A};
    checkLog("r7E", eu, el);

    $display("[TB] transmitter busy when the request arrives");
    clearLogs(); d0 = done_cnt[0];
    ext_busy = 1'b1;
    applyStimulus(8'hC3);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("withheld_strobes", log0.size(), 0);
    ext_busy = 1'b0;
    waitStrobes(1, 20);
    checkOutput("withheld_single", log0.size(), 1);
    waitDone(d0 + 1, 200, 1'b0);
    eu = '{8'h43, 8'h33, 8'h0D, 8'h0A}; el = '{8'h63, 8'h33, 8'h0D, 8'h0A};
    checkLog("rC3", eu, el);

    $display("[TB] randomized reports");
    for (int r = 0; r < 30; r++) begin
      int gap;
      int hb;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      d0 = done_cnt[0];
      if ($urandom_range(0, 3) == 0) begin
        hb = $urandom_range(1, 6);
        ext_busy = 1'b1;
        applyStimulus(8'($urandom));
        repeat (hb) @(posedge clk);
        #1;
        ext_busy = 1'b0;
      end else begin
        applyStimulus(8'($urandom));
      end
      gap = 0;
      waitDone(d0 + 1, 300, 1'b1);
    end

    repeat (20) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_report_tx.md
HEX_REPORT_TX -- requirements
Module: hex_report_tx

Interface
REQ-001 Parameter HEX_UPPER, default 1: 1 selects ASCII 'A'-'F' (0x41-0x46) for nibbles 10-15; 0 selects 'a'-'f' (0x61-0x66).
REQ-002 i_clk  input  1  single clock; all state on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_send  input  1  one-cycle request to report i_value.
REQ-005 i_value  input  8  byte to report as two ASCII hex characters.
REQ-006 i_tx_busy  input  1  busy flag from the downstream UART transmitter.
REQ-007 o_tx_dr  output  1  one-cycle data-ready strobe to the transmitter.
REQ-008 o_tx_data  output  8  ASCII character presented with o_tx_dr.
REQ-009 o_busy  output  1  high from request acceptance until the last character completes.
REQ-010 o_done  output  1  one-cycle pulse when the last character completes.
REQ-011 o_overrun  output  1  one-cycle pulse when i_send is rejected.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO and NEXT.
REQ-013 IDLE: when i_send=1, the block SHALL latch i_value into an internal register, clear the character index to 0, set o_busy=1, and go to LOAD on the next edge.
REQ-014 LOAD: o_tx_data SHALL be registered from the character selected by the index (index 0 = upper nibble, index 1 = lower nibble, then the terminator characters per REQ-027), then the block SHALL go to STROBE.
REQ-015 STROBE: the block SHALL wait until i_tx_busy=0, then assert o_tx_dr for exactly one cycle and go to WAIT_HI.
REQ-016 WAIT_HI: the block SHALL remain until i_tx_busy=1, then go to WAIT_LO.
REQ-017 WAIT_LO: the block SHALL remain until i_tx_busy=0, then go to NEXT.
REQ-018 NEXT: if the index equals the last index, the block SHALL pulse o_done, clear o_busy, and return to IDLE; otherwise it SHALL increment the index and go to LOAD.
REQ-019 Nibble encoding SHALL map 0-9 to 0x30-0x39 and 10-15 per HEX_UPPER.
REQ-020 o_tx_data SHALL hold its value, unchanged, from LOAD until the next LOAD.
REQ-021 If i_send=1 in any state other than IDLE, the block SHALL pulse o_overrun for one cycle and leave the latched value and sequence unaffected.
REQ-022 If i_send=1 in IDLE, o_overrun SHALL stay 0.
REQ-023 On the cycle that o_done pulses, i_send SHALL count as outside IDLE; an i_send on the following cycle SHALL be accepted.
REQ-024 Latency SHALL be 3 cycles from accepted i_send to the first o_tx_dr when i_tx_busy=0.

Reset
REQ-025 When i_reset=0, the block SHALL asynchronously force state to IDLE, set the index to 0 and the latched value to 0x00, and drive all outputs to 0 (o_tx_data=0x00).
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no o_done; the first i_send after reset release SHALL start a fresh sequence at index 0.

Configuration
REQ-027 With macro HEX_REPORT_CRLF_EN defined, the last index SHALL be 3, and indices 2 and 3 SHALL send 0x0D and 0x0A; without the macro, the last index SHALL be 1 and only the two hex characters SHALL be sent.

Structure
REQ-028 The state encoding, the ASCII constants (0x30, 0x41, 0x61, 0x0D, 0x0A) and the last-index constants SHALL reside in a shared package, hex_report_pkg.
REQ-029 Nibble-to-ASCII conversion SHALL be one sub-module, nibble_to_ascii (4-bit in, 8-bit out, HEX_UPPER passed through); sequencing SHALL stay in hex_report_tx.

Verification
REQ-030 Transmitter model: i_tx_busy rises 1 cycle after o_tx_dr and is held 10 cycles. Stimulus: i_value=0x4A, HEX_UPPER=1, no macro -> o_tx_data 0x34 then 0x41, exactly 2 o_tx_dr strobes, one o_done.
REQ-031 Same stimulus with HEX_REPORT_CRLF_EN defined -> o_tx_data 0x34, 0x41, 0x0D, 0x0A; 4 strobes; o_done after the 4th busy fall.
REQ-032 i_value=0xFB, HEX_UPPER=0 -> 0x66, 0x62; i_value=0x00 -> 0x30, 0x30.
REQ-033 i_send with 0x11 during the second character of a 0x4A report -> o_overrun pulses once, output sequence stays 0x34, 0x41, and no 0x31 is ever sent.
REQ-034 i_reset=0 during WAIT_LO of the first character -> all outputs 0 within the same cycle, no o_done; a later i_send with 0x7E -> 0x37, 0x45.
REQ-035 i_tx_busy held high when i_send arrives -> o_tx_dr is withheld until busy falls, then strobes once.
